// File: rtl/mod_pkg.sv
// mod_pkg: shared modes, FSM states and LFSR seed for the mod_sched modulator
package mod_pkg;
  typedef enum logic [1:0] {MOD_PASS, MOD_BASK, MOD_BPSK, MOD_FSK} mode_t;
  typedef enum logic [1:0] {IDLE, RUN, DRAIN} state_t;
  localparam logic [4:0] LFSR_SEED = 5'b00001;
endpackage

// File: rtl/mod_sched_lfsr.sv
// mod_sched_lfsr: 5-bit Fibonacci LFSR (x^5+x^3+1) supplying one data bit per symbol
import mod_pkg::*;
module mod_sched_lfsr (
  input  logic       clk,
  input  logic       rst,
  input  logic       en,
  output logic [4:0] q
);
  // shift right, feedback into bit 4; bit 0 is the applied data bit
  always_ff @(posedge clk or negedge rst)
    if (!rst) q <= LFSR_SEED;
    else if (en) q <= {q[3] ^ q[0], q[4:1]};
endmodule

// File: rtl/mod_sched.sv
// mod_sched: symbol-scheduled BASK/BPSK/FSK modulator; FSK gated by MOD_SCHED_FSK_EN
import mod_pkg::*;
module mod_sched #(
  parameter int DIN_W = 12,
  parameter int DIV_W = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             stop,
  input  logic [1:0]       mod_sel,
  input  logic [DIV_W-1:0] sym_div,
  input  logic [DIN_W-1:0] car_in,
  input  logic [DIN_W-1:0] car_hi_in,
  output logic [DIN_W-1:0] dout,
  output logic             dout_valid,
  output logic             busy,
  output logic             sym_tick,
  output logic             bit_out
);
  localparam logic [DIN_W-1:0] SMIN = {1'b1, {(DIN_W-1){1'b0}}};
  localparam logic [DIN_W-1:0] SMAX = ~SMIN;
  state_t state, nxt;
  mode_t mode;
  logic [DIV_W-1:0] per, cnt;
  logic [4:0] lfsr;
  logic [DIN_W-1:0] neg, samp;
  assign busy = state != IDLE;
  assign sym_tick = busy && cnt == per - 1'b1;
  assign bit_out = lfsr[0];
  // the final DRAIN tick closes the stream without consuming a new bit
  mod_sched_lfsr u_lfsr (.clk(clk), .rst(rst), .en(sym_tick && state == RUN), .q(lfsr));
  // next state: start leaves IDLE, stop arms DRAIN, DRAIN ends on its tick
  always_comb begin
    nxt = state;
    nxt = state == IDLE ? (start ? RUN : IDLE) :
          state == RUN  ? (stop ? DRAIN : RUN) :
                          (sym_tick ? IDLE : DRAIN);
  end
  // state register
  always_ff @(posedge clk or negedge rst)
    if (!rst) state <= IDLE;
    else state <= nxt;
  // symbol counter and start-time configuration latch
  always_ff @(posedge clk or negedge rst)
    if (!rst) begin
      cnt  <= '0;
      per  <= DIV_W'(1);
      mode <= MOD_PASS;
    end else if (state == IDLE) begin
      cnt <= '0;
      if (start) begin
        mode <= mode_t'(mod_sel);
        per  <= sym_div == '0 ? DIV_W'(1) : sym_div;
      end
    end else cnt <= sym_tick ? '0 : cnt + 1'b1;
  // sample selection with saturating BPSK inversion
  always_comb begin
    neg = car_in == SMIN ? SMAX : -car_in;
    samp = car_in;
`ifdef MOD_SCHED_FSK_EN
    samp = mode == MOD_BASK ? (bit_out ? car_in : '0) :
           mode == MOD_BPSK ? (bit_out ? car_in : neg) :
           mode == MOD_FSK  ? (bit_out ? car_hi_in : car_in) : car_in;
`else
    samp = mode == MOD_BASK ? (bit_out ? car_in : '0) :
           mode == MOD_BPSK ? (bit_out ? car_in : neg) : car_in;
`endif
  end
`ifndef MOD_SCHED_FSK_EN
  logic unused_hi;
  assign unused_hi = ^car_hi_in;
`endif
  // registered output, zero whenever no symbol is in flight
  always_ff @(posedge clk or negedge rst)
    if (!rst) begin
      dout       <= '0;
      dout_valid <= 1'b0;
    end else begin
      dout       <= busy ? samp : '0;
      dout_valid <= busy;
    end
endmodule

// File: tb/tb_mod_sched.sv
// tb_mod_sched: scoreboard bench for mod_sched against a cycle model
module tb_mod_sched;
  localparam int W = 12;
  localparam int D = 16;
  logic clk = 0, rst = 0, start = 0, stop = 0;
  logic [1:0] mod_sel = 0;
  logic [D-1:0] sym_div = 0;
  logic [W-1:0] car_in = 0, car_hi_in = 0, dout;
  logic dout_valid, busy, sym_tick, bit_out;
  mod_sched #(.DIN_W(W), .DIV_W(D)) dut (
    .clk(clk), .rst(rst), .start(start), .stop(stop), .mod_sel(mod_sel),
    .sym_div(sym_div), .car_in(car_in), .car_hi_in(car_hi_in), .dout(dout),
    .dout_valid(dout_valid), .busy(busy), .sym_tick(sym_tick), .bit_out(bit_out)
  );
  always #5 clk = ~clk;
  typedef struct packed {logic [W-1:0] d; logic v;} exp_t;
  exp_t q[$];
  int total = 0, bad = 0;
  int ms = 0, mcnt = 0, mper = 1;
  logic [1:0] mmode = 0;
  logic [4:0] ml = 5'b00001;
  int seqv[5] = '{1, 0, 0, 0, 0};

  task chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h t=%0t", tag, got, exp, $time);
    end
  endtask

  function logic [W-1:0] mod_val(input logic [1:0] m, input logic b, input logic [W-1:0] c, input logic [W-1:0] h);
    int s;
    s = int'($signed(c));
    case (m)
      2'd1: return b ? c : '0;
      2'd2: return b ? c : (s == -2048 ? 12'h7FF : W'(-s));
`ifdef MOD_SCHED_FSK_EN
      2'd3: return b ? h : c;
`endif
      default: return c;
    endcase
  endfunction

  function logic mtick();
    return ms != 0 && mcnt == mper - 1;
  endfunction

  task step();
    exp_t e;
    logic tk;
    tk = mtick();
    e.v = ms != 0;
    e.d = ms != 0 ? mod_val(mmode, ml[0], car_in, car_hi_in) : '0;
    q.push_back(e);
    case (ms)
      0: if (start) begin ms = 1; mmode = mod_sel; mper = sym_div == 0 ? 1 : int'(sym_div); mcnt = 0; end
      1: begin
        if (tk) ml = {ml[3] ^ ml[0], ml[4:1]};
        mcnt = tk ? 0 : mcnt + 1;
        if (stop) ms = 2;
      end
      default: begin mcnt = tk ? 0 : mcnt + 1; if (tk) ms = 0; end
    endcase
    @(posedge clk); #1;
    e = q.pop_front();
    chk("dout", dout, e.d);
    chk("valid", dout_valid, e.v);
    chk("busy", busy, ms != 0);
    chk("bit", bit_out, ml[0]);
    chk("tick", sym_tick, mtick());
    start = 0;
    stop = 0;
  endtask

  task run(input int n);
    for (int i = 0; i < n; i++) step();
  endtask

  task do_reset();
    #2 rst = 0;
    #1;
    chk("rst_dout", dout, 0);
    chk("rst_valid", dout_valid, 0);
    chk("rst_busy", busy, 0);
    chk("rst_tick", sym_tick, 0);
    chk("rst_bit", bit_out, 1);
    ms = 0; mcnt = 0; mper = 1; mmode = 0; ml = 5'b00001;
    q.delete();
    @(negedge clk) rst = 1;
  endtask

  initial begin
    int n;
    #12;
    chk("init_dout", dout, 0);
    chk("init_valid", dout_valid, 0);
    chk("init_busy", busy, 0);
    chk("init_bit", bit_out, 1);
    @(negedge clk) rst = 1;
    run(2);
    mod_sel = 2'd1; sym_div = 4; car_in = 12'h3FF; start = 1;
    step();
    run(40);
    mod_sel = 2'd2; start = 1;
    step();
    run(8);
    stop = 1;
    step();
    run(6);
    stop = 1;
    step();
    mod_sel = 2'd2; sym_div = 2; car_in = 12'h800; start = 1; stop = 1;
    step();
    run(14);
    car_in = 12'h100;
    run(14);
    stop = 1;
    step();
    run(4);
    do_reset();
    mod_sel = 2'd0; sym_div = 0; start = 1;
    step();
    for (int k = 0; k < 5; k++) begin
      chk("seq", bit_out, seqv[k]);
      step();
    end
    stop = 1;
    step();
    run(3);
    mod_sel = 2'd1; sym_div = 3; car_in = 12'h3FF; start = 1;
    step();
    run(4);
    for (int i = 0; i < 10 && !mtick(); i++) step();
    chk("at_tick", sym_tick, 1);
    stop = 1;
    step();
    n = 0;
    for (int i = 0; i < 10 && busy; i++) begin n++; step(); end
    chk("drain_len", n, 3);
    step();
    chk("idle_dout", dout, 0);
    mod_sel = 2'd1; sym_div = 5; start = 1;
    step();
    run(7);
    do_reset();
    mod_sel = 2'd1; sym_div = 2; start = 1;
    step();
    run(12);
    stop = 1;
    step();
    run(4);
    mod_sel = 2'd3; sym_div = 2; car_in = 12'h001; car_hi_in = 12'h002; start = 1;
    step();
    run(30);
    stop = 1;
    step();
    run(4);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/mod_sched.md
MOD_SCHED -- requirements
Module: mod_sched

Interface
REQ-001 Parameter DIN_W, default 12, sample width of carrier inputs and modulated output (two's complement).
REQ-002 Parameter DIV_W, default 16, width of symbol-period divider.
REQ-003 clk  input  1  single system clock; all state updates on posedge clk.
REQ-004 rst  input  1  reset, asynchronous assert, active-low (rst=0 resets).
REQ-005 start  input  1  one-cycle request to begin modulating; latches mod_sel and sym_div.
REQ-006 stop  input  1  one-cycle request to end after the current symbol.
REQ-007 mod_sel  input  2  mode: 00 carrier pass-through, 01 BASK, 10 BPSK, 11 FSK.
REQ-008 sym_div  input  DIV_W  symbol period in clocks; 0 treated as 1.
REQ-009 car_in  input  DIN_W  carrier sample (bit=0 tone for FSK).
REQ-010 car_hi_in  input  DIN_W  alternate carrier sample (bit=1 tone for FSK).
REQ-011 dout  output  DIN_W  modulated sample, registered.
REQ-012 dout_valid  output  1  high when dout carries a modulated sample.
REQ-013 busy  output  1  high in any state other than IDLE.
REQ-014 sym_tick  output  1  one-cycle pulse on the last clock of each symbol.
REQ-015 bit_out  output  1  data bit currently applied.

Function
REQ-016 FSM states SHALL be IDLE, RUN and DRAIN.
REQ-017 Transition IDLE->RUN SHALL occur on start=1; mod_sel and max(sym_div,1) SHALL be latched and the symbol counter cleared in that cycle.
REQ-018 start while busy=1 SHALL be ignored.
REQ-019 In RUN and DRAIN the symbol counter SHALL count 0..P-1 (P = latched period); sym_tick=1 when count=P-1, and the counter SHALL wrap to 0 in the next cycle.
REQ-020 On each sym_tick the data bit SHALL advance to the next output of a 5-bit Fibonacci LFSR, polynomial x^5+x^3+1, seed 5'b00001; bit_out = LFSR bit 0.
REQ-021 stop in RUN SHALL move to DRAIN; DRAIN SHALL go to IDLE in the cycle after the next sym_tick, without advancing the bit on that tick.
REQ-022 stop and sym_tick in the same RUN cycle SHALL still complete one full further symbol in DRAIN.
REQ-023 stop in IDLE or DRAIN SHALL be ignored; start and stop together in IDLE SHALL act as start only.
REQ-024 dout SHALL be registered one cycle after the sample used: mode 00 car_in; 01 bit ? car_in : 0; 10 bit ? car_in : -car_in; 11 bit ? car_hi_in : car_in.
REQ-025 BPSK negation SHALL saturate: -(-2^(DIN_W-1)) = 2^(DIN_W-1)-1.
REQ-026 dout_valid SHALL be 1 exactly in cycles whose dout was computed in RUN or DRAIN; otherwise dout SHALL be 0.
REQ-027 LFSR state SHALL persist across IDLE; it is reseeded only by reset.

Reset
REQ-028 rst=0 SHALL immediately force IDLE, counter 0, LFSR 5'b00001, dout 0, dout_valid 0, busy 0, sym_tick 0, bit_out 1.
REQ-029 Reset mid-symbol SHALL abandon the symbol; no sym_tick is emitted.

Configuration
REQ-030 Macro MOD_SCHED_FSK_EN defined: mode 11 is FSK per REQ-024.
REQ-031 Macro MOD_SCHED_FSK_EN undefined: mode 11 SHALL behave as mode 00; car_hi_in remains a port but is unused.

Structure
REQ-032 Package mod_pkg SHALL hold the mode enum (MOD_PASS, MOD_BASK, MOD_BPSK, MOD_FSK), the FSM state enum and the LFSR seed constant.
REQ-033 The LFSR SHALL be a sub-module mod_sched_lfsr with enable (sym_tick) and asynchronous active-low reset.

Verification
REQ-034 Reset, start with mod_sel=01, sym_div=4, car_in=12'h3FF -> dout_valid rises 1 cycle after RUN entry; sym_tick every 4 clocks; dout = 12'h3FF when bit=1, 0 when bit=0.
REQ-035 mod_sel=10, car_in=12'h800, bit=0 -> dout=12'h7FF (saturated); car_in=12'h100, bit=0 -> dout=12'hF00.
REQ-036 sym_div=0 -> sym_tick every clock; first five bit_out values after reset are 1,0,0,0,0 per the LFSR sequence from seed 00001.
REQ-037 stop on the same cycle as sym_tick with sym_div=3 -> exactly 3 further valid cycles, then busy=0 and dout=0.
REQ-038 rst=0 pulsed mid-symbol -> all outputs 0 (bit_out 1) asynchronously; later start resumes from LFSR seed.
REQ-039 mod_sel=11 with car_in=12'h001, car_hi_in=12'h002 -> with MOD_SCHED_FSK_EN dout tracks bit; without it dout=12'h001 always.
